// File: rtl/imem_loader_if.sv
// Loader byte stream, core fetch port and status lines of the instruction loader.
// The slave modport is the loader's view; the master modport is the stream source and core side.
interface imem_loader_if;
  logic [7:0]  ld_data;
  logic        ld_valid;
  logic        ld_ready;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata;
  logic        holt;
  logic        core_rst_n;
  logic        busy;
  logic        err;

  modport master (
    output ld_data, ld_valid, imem_addr, holt,
    input  ld_ready, imem_rdata, core_rst_n, busy, err
  );

  modport slave (
    input  ld_data, ld_valid, imem_addr, holt,
    output ld_ready, imem_rdata, core_rst_n, busy, err
  );
endinterface

// File: rtl/imem_loader.sv
// Program loader: assembles a big-endian byte stream into 16-bit words, stores them,
// and holds the core in reset until the whole program has been received.
module imem_loader #(
  parameter int imem_size = 32
) (
  input  logic         clk,
  input  logic         rst,
  imem_loader_if.slave bus
);
  localparam int AW = $clog2(imem_size);

  typedef enum logic [2:0] {
    HDR_HI,
    HDR_LO,
    WORD_HI,
    WORD_LO,
    RUN,
    ERR
  } state_t;

  state_t      state;
  logic [15:0] n_words;
  logic [AW:0] wr_ptr;
  logic [7:0]  hi_byte;
  logic [15:0] mem [imem_size];
  logic        ld_ready_q;
  logic        core_rst_n_q;
  logic        err_q;

  logic        xfer;
  logic [15:0] hdr_full;
  logic        last_word;

  always_comb begin
    xfer      = bus.ld_valid && ld_ready_q;
    hdr_full  = {n_words[15:8], bus.ld_data};
    last_word = (16'(wr_ptr) == (n_words - 16'd1));
  end

  // Outputs are registered alongside the state, so each transition sets them
  // to the decode of the state being entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= HDR_HI;
      n_words      <= '0;
      wr_ptr       <= '0;
      hi_byte      <= '0;
      mem          <= '{default: '0};
      ld_ready_q   <= 1'b1;
      core_rst_n_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      case (state)
        HDR_HI: begin
          if (xfer) begin
            n_words[15:8] <= bus.ld_data;
            state         <= HDR_LO;
          end
        end
        HDR_LO: begin
          if (xfer) begin
            n_words[7:0] <= bus.ld_data;
            wr_ptr       <= '0;
            if (hdr_full == 16'd0) begin
              state        <= RUN;
              ld_ready_q   <= 1'b0;
              core_rst_n_q <= 1'b1;
            end else if ({1'b0, hdr_full} > 17'(imem_size)) begin
              state      <= ERR;
              ld_ready_q <= 1'b0;
              err_q      <= 1'b1;
            end else begin
              state <= WORD_HI;
            end
          end
        end
        WORD_HI: begin
          if (xfer) begin
            hi_byte <= bus.ld_data;
            state   <= WORD_LO;
          end
        end
        WORD_LO: begin
          if (xfer) begin
            mem[wr_ptr[AW-1:0]] <= {hi_byte, bus.ld_data};
            if (last_word) begin
              state        <= RUN;
              ld_ready_q   <= 1'b0;
              core_rst_n_q <= 1'b1;
            end else begin
              wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
              state  <= WORD_HI;
            end
          end
        end
        RUN: begin
          if (bus.holt) begin
            state        <= HDR_HI;
            ld_ready_q   <= 1'b1;
            core_rst_n_q <= 1'b0;
          end
        end
        ERR: begin
        end
        default: begin
          state        <= HDR_HI;
          ld_ready_q   <= 1'b1;
          core_rst_n_q <= 1'b0;
          err_q        <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    bus.imem_rdata = '0;
    if ({1'b0, bus.imem_addr} < 17'(imem_size)) begin
      bus.imem_rdata = mem[bus.imem_addr[AW-1:0]];
    end
  end

  assign bus.ld_ready   = ld_ready_q;
  assign bus.busy       = ld_ready_q;
  assign bus.core_rst_n = core_rst_n_q;
  assign bus.err        = err_q;
endmodule
